// File: rtl/muldiv_sequencer.sv
// Iterative RV64 M-extension unit: shift-add multiply and restoring divide,
// one bit per cycle, with a one-cycle fast path for the RISC-V special cases.
module muldiv_sequencer #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);
  localparam int WW = 32;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [2:0]          op_q, op_d;
  logic                word_q, word_d;
  logic                sign_q, sign_d;
  logic                fast_q, fast_d;
  logic [XLEN-1:0]     fast_val_q, fast_val_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;   // multiplicand or divisor
  logic [XLEN-1:0]     result_q, result_d;
  logic                done_q, done_d;

  // launch-side operand conditioning, derived from the raw inputs
  logic            is_div, rem_op, a_sgn, b_sgn, a_neg, b_neg;
  logic            div0, ovf, illegal;
  logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, a_sx, min_neg, fast_val;

  // Form extended/absolute operands and the special-case result at launch.
  always_comb begin
    is_div  = op[2];
    rem_op  = op[1];
    a_sgn   = is_div ? ~op[0] : (op == 3'd1 || op == 3'd2);
    b_sgn   = is_div ? ~op[0] : (op == 3'd1);
    a_sx    = {{(XLEN-WW){a[WW-1]}}, a[WW-1:0]};
    a_ext   = word ? (a_sgn ? a_sx : {{(XLEN-WW){1'b0}}, a[WW-1:0]}) : a;
    b_ext   = word ? (b_sgn ? {{(XLEN-WW){b[WW-1]}}, b[WW-1:0]}
                            : {{(XLEN-WW){1'b0}}, b[WW-1:0]}) : b;
    a_neg   = a_sgn & a_ext[XLEN-1];
    b_neg   = b_sgn & b_ext[XLEN-1];
    a_abs   = a_neg ? -a_ext : a_ext;
    b_abs   = b_neg ? -b_ext : b_ext;
    min_neg = word ? {{(XLEN-WW+1){1'b1}}, {(WW-1){1'b0}}}
                   : {1'b1, {(XLEN-1){1'b0}}};
    illegal = word && (op == 3'd1 || op == 3'd2 || op == 3'd3);
    div0    = is_div && (b_ext == '0);
    ovf     = is_div && ~op[0] && (a_ext == min_neg) && (b_ext == '1);
    fast_val = '0;
    if (illegal)   fast_val = '0;
    else if (div0) fast_val = rem_op ? (word ? a_sx : a) : '1;
    else if (ovf)  fast_val = rem_op ? '0 : min_neg;
  end

  // per-iteration datapath and final result selection
  logic [XLEN:0]     sum, rem_sh, diff;
  logic [2*XLEN-1:0] prod_full, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fin_raw, fin_val;

  // One shift-add / trial-subtract step, plus sign fix-up for FIN.
  always_comb begin
    sum       = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
    rem_sh    = acc_q[2*XLEN-1:XLEN-1];
    diff      = rem_sh - {1'b0, opnd_q};
    // word multiplies run only 32 steps, so the product sits 32 bits high
    prod_full = word_q ? (acc_q >> (XLEN - WW)) : acc_q;
    prod_s    = sign_q ? -prod_full : prod_full;
    quo_s     = sign_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_s     = sign_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (op_q[2])           fin_raw = op_q[1] ? rem_s : quo_s;
    else if (op_q == 3'd0) fin_raw = prod_s[XLEN-1:0];
    else                   fin_raw = prod_s[2*XLEN-1:XLEN];
    fin_val = word_q ? {{(XLEN-WW){fin_raw[WW-1]}}, fin_raw[WW-1:0]} : fin_raw;
    if (fast_q) fin_val = fast_val_q;
  end

  // Next-state and register-update logic for IDLE/CALC/FIN.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    op_d       = op_q;
    word_d     = word_q;
    sign_d     = sign_q;
    fast_d     = fast_q;
    fast_val_d = fast_val_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    result_d   = result_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !kill) begin
          op_d       = op;
          word_d     = word;
          sign_d     = (is_div && rem_op) ? a_neg : (a_neg ^ b_neg);
          fast_d     = illegal || div0 || ovf;
          fast_val_d = fast_val;
          opnd_d     = is_div ? b_abs : a_abs;
          // word divides preload the dividend high so its bits reach the
          // remainder within 32 steps
          if (is_div) acc_d = {{XLEN{1'b0}}, word ? (a_abs << (XLEN - WW)) : a_abs};
          else        acc_d = {{XLEN{1'b0}}, b_abs};
          count_d    = word ? CW'(WW) : CW'(XLEN);
          state_d    = (illegal || div0 || ovf) ? FIN : CALC;
        end
      end
      CALC: begin
        if (kill) begin
          state_d = IDLE;
        end else begin
          if (op_q[2]) begin
            if (!diff[XLEN]) acc_d = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            else             acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
          end else begin
            if (acc_q[0]) acc_d = {sum, acc_q[XLEN-1:1]};
            else          acc_d = acc_q >> 1;
          end
          count_d = count_q - CW'(1);
          if (count_q == CW'(1)) state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
        if (!kill) begin
          result_d = fin_val;
          done_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      op_q       <= '0;
      word_q     <= 1'b0;
      sign_q     <= 1'b0;
      fast_q     <= 1'b0;
      fast_val_q <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      op_q       <= op_d;
      word_q     <= word_d;
      sign_q     <= sign_d;
      fast_q     <= fast_d;
      fast_val_q <= fast_val_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      result_q   <= result_d;
      done_q     <= done_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer against an arithmetic reference.
module tb_muldiv_sequencer;
  logic        clk = 1'b0;
  logic        rst, start, word, kill;
  logic [2:0]  op;
  logic [63:0] a, b;
  logic        busy, done;
  logic [63:0] result;

  int checks = 0;
  int errors = 0;
  logic [63:0] last_exp = '0;

  muldiv_sequencer #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .word(word),
    .a(a), .b(b), .kill(kill), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // RISC-V M semantics from plain arithmetic
  function automatic logic [63:0] ref_res(input logic [2:0] o, input logic w,
                                          input logic [63:0] x, input logic [63:0] y);
    logic signed [127:0] pa, pb, pp;
    logic signed [63:0]  sa, sb, smin;
    logic [63:0]         ua, ub, q, r;
    if (w) begin
      sa = sx32(x[31:0]); sb = sx32(y[31:0]);
      ua = {32'd0, x[31:0]}; ub = {32'd0, y[31:0]};
      smin = 64'hFFFF_FFFF_8000_0000;
    end else begin
      sa = x; sb = y; ua = x; ub = y;
      smin = 64'h8000_0000_0000_0000;
    end
    if (o[2]) begin
      if (!o[0]) begin
        if (sb == 0)                   begin q = '1; r = sa; end
        else if (sa == smin && sb == -1) begin q = smin; r = 0; end
        else                           begin q = sa / sb; r = sa % sb; end
      end else begin
        if (ub == 0) begin q = '1; r = ua; end
        else         begin q = ua / ub; r = ua % ub; end
      end
      if (w) return sx32(o[1] ? r[31:0] : q[31:0]);
      return o[1] ? r : q;
    end
    if (w) begin
      if (o != 3'd0) return '0;
      q = ua * ub;
      return sx32(q[31:0]);
    end
    case (o)
      3'd0:    begin pa = {64'd0, x}; pb = {64'd0, y}; end
      3'd1:    begin pa = {{64{x[63]}}, x}; pb = {{64{y[63]}}, y}; end
      3'd2:    begin pa = {{64{x[63]}}, x}; pb = {64'd0, y}; end
      default: begin pa = {64'd0, x}; pb = {64'd0, y}; end
    endcase
    pp = pa * pb;
    return (o == 3'd0) ? pp[63:0] : pp[127:64];
  endfunction

  // cycles from the start edge until done is visible
  function automatic int ref_lat(input logic [2:0] o, input logic w,
                                 input logic [63:0] x, input logic [63:0] y);
    if (w && o inside {3'd1, 3'd2, 3'd3}) return 1;
    if (o[2]) begin
      if (w ? (y[31:0] == 0) : (y == 0)) return 1;
      if (!o[0] && (w ? (x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF)
                      : (x == 64'h8000_0000_0000_0000 && y == '1))) return 1;
    end
    return w ? 33 : 65;
  endfunction

  // Call at a negedge. poke: re-pulse start mid-op with other operands.
  // chain: return in the done cycle so the next op starts there.
  task automatic do_op(input logic [2:0] o, input logic w, input logic [63:0] x,
                       input logic [63:0] y, input bit poke, input bit chain, input string tag);
    int cyc, bsy, el;
    logic [63:0] exp;
    exp = ref_res(o, w, x, y);
    el  = ref_lat(o, w, x, y);
    op = o; word = w; a = x; b = y; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 0; bsy = 0;
    chk({tag, "/done_low"}, {63'd0, done}, 64'd0);
    if (busy) bsy++;
    while (!done && cyc < 200) begin
      if (poke && cyc == 3) begin start = 1'b1; op = 3'd0; word = 1'b0; a = 64'd3; b = 64'd3; end
      if (poke && cyc == 6) start = 1'b0;
      @(negedge clk);
      cyc++;
      if (busy) bsy++;
    end
    start = 1'b0;
    chk({tag, "/latency"}, 64'(cyc), 64'(el));
    chk({tag, "/busy_cycles"}, 64'(bsy), 64'(el));
    chk({tag, "/result"}, result, exp);
    last_exp = exp;
    if (!chain) begin
      @(negedge clk);
      chk({tag, "/done_pulse"}, {63'd0, done}, 64'd0);
    end
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'h8000_0000_0000_0000;
      3:       return ($urandom_range(0, 1) != 0) ? 64'($urandom_range(0, 20)) : -64'($urandom_range(1, 20));
      4:       return {32'd0, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    int dseen;
    rst = 1'b1; start = 1'b0; kill = 1'b0; op = '0; word = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset/busy", {63'd0, busy}, 64'd0);
    chk("reset/done", {63'd0, done}, 64'd0);
    chk("reset/result", result, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // directed cases
    do_op(3'd5, 1'b0, 64'd100, 64'd7, 1'b1, 1'b0, "divu_poke");
    do_op(3'd7, 1'b0, 64'd100, 64'd7, 1'b0, 1'b0, "remu");
    do_op(3'd6, 1'b0, -64'd7, 64'd2, 1'b0, 1'b0, "rem_neg");
    do_op(3'd4, 1'b0, -64'd7, 64'd2, 1'b0, 1'b0, "div_neg");
    do_op(3'd4, 1'b0, 64'd5, 64'd0, 1'b0, 1'b0, "div_by0");
    do_op(3'd7, 1'b0, 64'd5, 64'd0, 1'b0, 1'b0, "remu_by0");
    do_op(3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 1'b0, 1'b0, "div_ovf");
    do_op(3'd3, 1'b0, '1, '1, 1'b0, 1'b0, "mulhu");
    do_op(3'd1, 1'b0, '1, '1, 1'b0, 1'b0, "mulh");
    do_op(3'd2, 1'b0, '1, 64'd2, 1'b0, 1'b0, "mulhsu");
    do_op(3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 1'b0, 1'b0, "mulw");
    do_op(3'd4, 1'b1, 64'h0000_0000_8000_0000, '1, 1'b0, 1'b0, "divw_ovf");
    do_op(3'd6, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 1'b0, 1'b0, "remw");
    do_op(3'd3, 1'b1, 64'd9, 64'd9, 1'b0, 1'b0, "mulhuw_illegal");
    do_op(3'd7, 1'b1, 64'hABCD_0000_8000_0001, 64'hFFFF_FFFF_0000_0000, 1'b0, 1'b0, "remuw_by0");
    // back-to-back: second start lands in the done cycle
    do_op(3'd0, 1'b0, 64'd6, 64'd7, 1'b0, 1'b1, "b2b_mul");
    do_op(3'd5, 1'b0, 64'd1000, 64'd10, 1'b0, 1'b0, "b2b_divu");

    // kill during CALC
    op = 3'd4; word = 1'b0; a = 64'd1000; b = 64'd3; start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill/busy", {63'd0, busy}, 64'd0);
    chk("kill/result", result, last_exp);
    dseen = 0;
    repeat (70) begin @(negedge clk); if (done) dseen++; end
    chk("kill/no_done", 64'(dseen), 64'd0);

    // kill and start together while idle
    op = 3'd5; a = 64'd9; b = 64'd3; start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    chk("kill_start/busy", {63'd0, busy}, 64'd0);
    dseen = 0;
    repeat (3) begin @(negedge clk); if (done || busy) dseen++; end
    chk("kill_start/idle", 64'(dseen), 64'd0);

    // kill in the FIN cycle of a fast-path op
    op = 3'd4; a = 64'd77; b = 64'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("kill_fin/busy", {63'd0, busy}, 64'd1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_fin/done", {63'd0, done}, 64'd0);
    chk("kill_fin/result", result, last_exp);

    // async reset mid-op
    op = 3'd3; a = {$urandom, $urandom}; b = {$urandom, $urandom}; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid/busy", {63'd0, busy}, 64'd0);
    chk("rst_mid/done", {63'd0, done}, 64'd0);
    chk("rst_mid/result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // randomized ops
    for (int i = 0; i < 40; i++) begin
      logic [2:0] ro;
      logic       rw;
      ro = 3'($urandom_range(0, 7));
      rw = ($urandom_range(0, 2) == 0);
      do_op(ro, rw, rnd64(), rnd64(), 1'b0, ($urandom_range(0, 3) == 0), "rand");
    end
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
